// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA priority arbiter.
package dma_pkg;

  localparam int NUM_CH = 4;

  // Channel index, wide enough for NUM_CH channels.
  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Channel following ch in rotating order; wraps 3 -> 0 naturally in 2 bits.
  function automatic ch_idx_t next_ch(input ch_idx_t ch);
    return ch + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational winner selection: fixed (ch0 highest) or rotating from a pointer.
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  ch_idx_t           i_ptr,
  input  logic              i_rotating,
  output ch_idx_t           o_winner,
  output logic              o_valid
);

  // Fixed mode is rotating mode with the search starting at channel 0.
  ch_idx_t           w_base;
  logic [NUM_CH-1:0] w_rot;
  ch_idx_t           w_offset;

  assign w_base = i_rotating ? i_ptr : ch_idx_t'(0);

  // Rotate the request vector so bit 0 is the current highest-priority channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
      localparam ch_idx_t OFFS = ch_idx_t'(gi);
      assign w_rot[gi] = i_req[w_base + OFFS];
    end
  endgenerate

  // Lowest set bit of the rotated vector wins; descending scan leaves the lowest.
  always_comb begin
    w_offset = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_offset = ch_idx_t'(i);
    end
  end

  assign o_winner = w_base + w_offset;
  assign o_valid  = |i_req;

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: hold-request handshake with the CPU and one-hot channel grant.
module dma_priority_arbiter
  import dma_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_dreq,
  input  logic [NUM_CH-1:0] i_sw_req,
  input  logic [NUM_CH-1:0] i_mask,
  input  logic              i_rotating,
  input  logic              i_enable,
  input  logic              i_hlda,
  input  logic              i_xfer_done,
  output logic              o_hrq,
  output logic [NUM_CH-1:0] o_dack,
  output ch_idx_t           o_active_ch,
  output logic              o_ch_valid
);

  arb_state_t        r_state;
  ch_idx_t           r_ptr;
  logic              r_hrq;
  logic [NUM_CH-1:0] r_dack;
  ch_idx_t           r_active_ch;
  logic              r_ch_valid;

  arb_state_t        w_state_next;
  ch_idx_t           w_ptr_next;
  ch_idx_t           w_grant_ch;
  logic              w_grant_valid;
  logic [NUM_CH-1:0] w_dack_next;
  logic [NUM_CH-1:0] w_eff_req;
  ch_idx_t           w_winner;
  logic              w_any_req;

  assign w_eff_req = i_enable ? ((i_dreq | i_sw_req) & ~i_mask) : '0;

  dma_priority_encoder u_enc (
    .i_req      (w_eff_req),
    .i_ptr      (r_ptr),
    .i_rotating (i_rotating),
    .o_winner   (w_winner),
    .o_valid    (w_any_req)
  );

  // Next-state, pointer update and granted channel; the grant is frozen while in GRANT.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_grant_ch   = r_active_ch;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (i_hlda && w_any_req) begin
          w_state_next = ST_GRANT;
          w_grant_ch   = w_winner;
        end else if (i_hlda) begin
          w_state_next = ST_RELEASE;
        end else if (!w_any_req) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A completed service always advances the pointer, even if HLDA drops with it.
        if (i_xfer_done) begin
          w_ptr_next   = next_ch(r_active_ch);
          w_state_next = i_hlda ? ST_RELEASE : ST_IDLE;
        end else if (!i_hlda) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!i_hlda) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_grant_valid = (w_state_next == ST_GRANT);

  // One-hot acknowledge decode; at most one bit can match the granted index.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dack
      assign w_dack_next[gi] = w_grant_valid && (w_grant_ch == ch_idx_t'(gi));
    end
  endgenerate

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hrq       <= 1'b0;
      r_dack      <= '0;
      r_active_ch <= '0;
      r_ch_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_hrq       <= (w_state_next == ST_REQ) || (w_state_next == ST_GRANT);
      r_dack      <= w_dack_next;
      r_active_ch <= w_grant_valid ? w_grant_ch : ch_idx_t'(0);
      r_ch_valid  <= w_grant_valid;
    end
  end

  assign o_hrq       = r_hrq;
  assign o_dack      = r_dack;
  assign o_active_ch = r_active_ch;
  assign o_ch_valid  = r_ch_valid;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter with a grant scoreboard.
module tb_dma_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dreq, sw_req, mask;
  logic       rotating, enable, hlda, xfer_done;
  logic       hrq;
  logic [3:0] dack;
  logic [1:0] active_ch;
  logic       ch_valid;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_ch;
  logic [3:0] prev_dack = 4'b0;

  dma_priority_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_dreq      (dreq),
    .i_sw_req    (sw_req),
    .i_mask      (mask),
    .i_rotating  (rotating),
    .i_enable    (enable),
    .i_hlda      (hlda),
    .i_xfer_done (xfer_done),
    .o_hrq       (hrq),
    .o_dack      (dack),
    .o_active_ch (active_ch),
    .o_ch_valid  (ch_valid)
  );

  always #5 clk = ~clk;

  // Scoreboard: every new grant must match the next expected channel.
  always @(posedge clk) begin
    #1;
    if (dack != 4'b0 && prev_dack == 4'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant dack=%b active=%0d expected no grant", dack, active_ch);
      end else begin
        exp_ch = exp_q.pop_front();
        $display("grant: dack=%b active=%0d valid=%b expected ch%0d", dack, active_ch, ch_valid, exp_ch);
        if (dack !== (4'b0001 << exp_ch) || active_ch !== exp_ch[1:0] || ch_valid !== 1'b1) begin
          errors++;
          $display("FAIL grant_order dack=%b active=%0d valid=%b expected ch%0d", dack, active_ch, ch_valid, exp_ch);
        end
      end
    end
    prev_dack = dack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One full service: IDLE -> REQ -> GRANT -> RELEASE -> IDLE, expecting channel ch.
  task automatic do_service(input int ch);
    step();
    exp_q.push_back(ch);
    hlda = 1'b1;
    step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    hlda = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (hrq !== 1'b0) begin errors++; $display("FAIL reset_hrq hrq=%b expected 0", hrq); end
    checks++;
    if (dack !== 4'b0) begin errors++; $display("FAIL reset_dack dack=%b expected 0000", dack); end
    checks++;
    if (ch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid valid=%b expected 0", ch_valid); end
    checks++;
    if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_active active=%0d expected 0", active_ch); end
    rst = 1'b0;
    step();
    checks++;
    if (hrq !== 1'b0) begin errors++; $display("FAIL reset_idle hrq=%b expected 0", hrq); end
    $display("test_reset done");
  endtask

  task automatic test_fixed();
    rotating = 1'b0;
    dreq = 4'b1010;
    step();
    checks++;
    if (hrq !== 1'b1 || dack !== 4'b0) begin errors++; $display("FAIL fixed_hrq_latency hrq=%b dack=%b expected 1/0000", hrq, dack); end
    step();
    step();
    checks++;
    if (hrq !== 1'b1 || dack !== 4'b0) begin errors++; $display("FAIL fixed_wait_hlda hrq=%b dack=%b expected 1/0000", hrq, dack); end
    exp_q.push_back(1);
    hlda = 1'b1;
    step();
    checks++;
    if (dack !== 4'b0010 || active_ch !== 2'd1) begin errors++; $display("FAIL fixed_grant dack=%b active=%0d expected 0010/1", dack, active_ch); end
    dreq = 4'b0001;
    mask = 4'b1111;
    rotating = 1'b1;
    step();
    checks++;
    if (dack !== 4'b0010 || active_ch !== 2'd1 || hrq !== 1'b1) begin
      errors++; $display("FAIL grant_frozen dack=%b active=%0d hrq=%b expected 0010/1/1", dack, active_ch, hrq);
    end
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    checks++;
    if (dack !== 4'b0 || hrq !== 1'b0 || ch_valid !== 1'b0) begin
      errors++; $display("FAIL xfer_done_release dack=%b hrq=%b valid=%b expected 0000/0/0", dack, hrq, ch_valid);
    end
    mask = 4'b0;
    step();
    checks++;
    if (hrq !== 1'b0) begin errors++; $display("FAIL release_holds hrq=%b expected 0", hrq); end
    rotating = 1'b0;
    hlda = 1'b0;
    dreq = 4'b0;
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fixed_pending pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    $display("test_fixed done");
  endtask

  task automatic test_rotating();
    pulse_reset();
    rotating = 1'b1;
    dreq = 4'b1111;
    for (int i = 0; i < 5; i++) do_service(i % 4);
    dreq = 4'b0;
    step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rotating_pending pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    $display("test_rotating done");
  endtask

  task automatic test_enable();
    enable = 1'b0;
    dreq = 4'b1111;
    step();
    step();
    checks++;
    if (hrq !== 1'b0) begin errors++; $display("FAIL enable_gate hrq=%b expected 0", hrq); end
    dreq = 4'b0;
    enable = 1'b1;
    step();
    $display("test_enable done");
  endtask

  task automatic test_mask_sw();
    logic seen;
    seen = 1'b0;
    rotating = 1'b0;
    mask = 4'b0001;
    dreq = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | hrq;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mask_blocks hrq_seen=%b expected 0", seen); end
    mask = 4'b0;
    dreq = 4'b0;
    sw_req = 4'b0100;
    do_service(2);
    sw_req = 4'b0;
    step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sw_req_pending pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    $display("test_mask_sw done");
  endtask

  task automatic test_revoke();
    pulse_reset();
    rotating = 1'b1;
    dreq = 4'b0100;
    step();
    exp_q.push_back(2);
    hlda = 1'b1;
    step();
    hlda = 1'b0;
    dreq = 4'b0;
    step();
    checks++;
    if (dack !== 4'b0 || hrq !== 1'b0 || ch_valid !== 1'b0) begin
      errors++; $display("FAIL revoke_outputs dack=%b hrq=%b valid=%b expected 0000/0/0", dack, hrq, ch_valid);
    end
    step();
    checks++;
    if (hrq !== 1'b0) begin errors++; $display("FAIL revoke_idle hrq=%b expected 0", hrq); end
    dreq = 4'b1111;
    do_service(0);
    dreq = 4'b0;
    step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL revoke_pending pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    $display("test_revoke done");
  endtask

  task automatic test_done_and_revoke();
    pulse_reset();
    rotating = 1'b1;
    dreq = 4'b0100;
    step();
    exp_q.push_back(2);
    hlda = 1'b1;
    step();
    xfer_done = 1'b1;
    hlda = 1'b0;
    dreq = 4'b1111;
    step();
    xfer_done = 1'b0;
    checks++;
    if (dack !== 4'b0 || hrq !== 1'b0) begin errors++; $display("FAIL done_revoke_outputs dack=%b hrq=%b expected 0000/0", dack, hrq); end
    step();
    checks++;
    if (hrq !== 1'b1) begin errors++; $display("FAIL done_revoke_idle hrq=%b expected 1", hrq); end
    exp_q.push_back(3);
    hlda = 1'b1;
    step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    hlda = 1'b0;
    dreq = 4'b0;
    step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL done_revoke_pending pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    $display("test_done_and_revoke done");
  endtask

  task automatic test_reset_mid_grant();
    rotating = 1'b1;
    dreq = 4'b1111;
    do_service(0);
    step();
    exp_q.push_back(1);
    hlda = 1'b1;
    step();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (hrq !== 1'b0 || dack !== 4'b0 || ch_valid !== 1'b0 || active_ch !== 2'd0) begin
      errors++; $display("FAIL async_reset hrq=%b dack=%b valid=%b active=%0d expected all 0", hrq, dack, ch_valid, active_ch);
    end
    step();
    rst = 1'b0;
    hlda = 1'b0;
    checks++;
    if (hrq !== 1'b0) begin errors++; $display("FAIL reset_release_no_hrq hrq=%b expected 0", hrq); end
    do_service(0);
    dreq = 4'b0;
    step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL reset_restart_pending pending=%0d expected 0", exp_q.size()); exp_q.delete(); end
    $display("test_reset_mid_grant done");
  endtask

  task automatic test_drop_req();
    rotating = 1'b0;
    dreq = 4'b0001;
    step();
    checks++;
    if (hrq !== 1'b1) begin errors++; $display("FAIL drop_hrq_high hrq=%b expected 1", hrq); end
    dreq = 4'b0;
    step();
    checks++;
    if (hrq !== 1'b0) begin errors++; $display("FAIL drop_hrq_low hrq=%b expected 0", hrq); end
    step();
    step();
    checks++;
    if (dack !== 4'b0 || hrq !== 1'b0) begin errors++; $display("FAIL drop_no_dack dack=%b hrq=%b expected 0000/0", dack, hrq); end
    $display("test_drop_req done");
  endtask

  initial begin
    rst = 1'b1;
    dreq = 4'b0;
    sw_req = 4'b0;
    mask = 4'b0;
    rotating = 1'b0;
    enable = 1'b1;
    hlda = 1'b0;
    xfer_done = 1'b0;
    test_reset();
    test_fixed();
    test_rotating();
    test_enable();
    test_mask_sw();
    test_revoke();
    test_done_and_revoke();
    test_reset_mid_grant();
    test_drop_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
